// File: rtl/mips_control_fsm.sv
// -----------------------------------------------------------------------------
// mips_control_fsm
//   Multi-cycle MIPS control unit. It sequences FETCH / DECODE / EXECUTE / MEM /
//   WRITEBACK / BRANCH / JUMP / WAIT and drives the datapath enables and selects
//   for the current state. It also counts retired instructions.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   opcode         instruction opcode field from the IR
//   flag_*         instruction decoder flags (flag_J_type: 0 none, 1 j/jal, 2 jr)
//   mult_operation, mflo_flag, immediate_src
//                  decoder flags (immediate_src selects the UART-copy path)
//   zero           ALU zero flag, used by BRANCH
//   mult_done      multiplier result ready (level)
//   uart_rx_valid  UART RX buffer holds a byte
//   pc_write .. alu_src_a   datapath enables and selects
//   pc_src         00 PC+4, 01 branch target, 10 jump target, 11 register
//   alu_src_b      00 reg B, 01 const 4, 10 immediate, 11 shifted immediate
//   mult_start     one-cycle multiplier start pulse (in DECODE)
//   uart_rx_ack    one-cycle RX buffer pop (in WAIT, UART reason)
//   state          current state code for debug
//   instr_retired  completed-instruction count, wraps at 2^32
// -----------------------------------------------------------------------------
module mips_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        flag_R_type,
  input  logic        flag_I_type,
  input  logic        flag_lw,
  input  logic        flag_sw,
  input  logic        mult_operation,
  input  logic        mflo_flag,
  input  logic        immediate_src,
  input  logic [1:0]  flag_J_type,
  input  logic        zero,
  input  logic        mult_done,
  input  logic        uart_rx_valid,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_write,
  output logic        reg_write,
  output logic        iord,
  output logic        alu_src_a,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_b,
  output logic        mult_start,
  output logic        uart_rx_ack,
  output logic [2:0]  state,
  output logic [31:0] instr_retired
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_BRANCH    = 3'd5,
    S_JUMP      = 3'd6,
    S_WAIT      = 3'd7
  } state_e;

  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_LUI = 6'h0F;

  state_e      state_q, state_d;
  logic        wait_uart_q, wait_uart_d;  // wait reason: 1 = UART, 0 = MULT
  logic [31:0] retired_q, retired_d;

  logic is_branch, is_store, br_taken, no_wb;

  // mflo needs no special sequencing; it takes the default ALU path.
  logic unused_flags;
  assign unused_flags = mflo_flag;

  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
  // lui shares flag_sw with stores in this decoder, so it is excluded here.
  assign is_store  = flag_sw && (opcode != OP_LUI);
  assign br_taken  = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
  // R-type mult and jr write no register.
  assign no_wb     = flag_R_type && (mult_operation || (flag_J_type == 2'd2));

  // Next-state and retired-counter logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; a missing default would infer a latch.
    state_d     = state_q;
    wait_uart_d = wait_uart_q;
    retired_d   = retired_q;
    unique case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        wait_uart_d = immediate_src;
        if (flag_J_type != 2'd0)                 state_d = S_JUMP;
        else if (is_branch)                      state_d = S_BRANCH;
        else if (immediate_src || mult_operation) state_d = S_WAIT;
        else                                     state_d = S_EXECUTE;
      end
      S_EXECUTE: state_d = (flag_lw || is_store) ? S_MEM : S_WRITEBACK;
      S_MEM:     state_d = flag_lw ? S_WRITEBACK : S_FETCH;
      S_WRITEBACK, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_WAIT: begin
        if (wait_uart_q) begin
          if (uart_rx_valid) state_d = S_WRITEBACK;
        end else if (mult_done) begin
          state_d = S_FETCH;
        end
      end
      default:   state_d = S_FETCH;
    endcase
    // Count each return to FETCH; the 32-bit add wraps naturally.
    if ((state_d == S_FETCH) && (state_q != S_FETCH)) retired_d = retired_q + 32'd1;
  end

  // Outputs are decoded from the state register. They stay combinational
  // because BRANCH and WAIT must react to zero / uart_rx_valid in the same
  // cycle. They are also gated by reset so that FETCH (code 0) drives nothing
  // while reset is held.
  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    iord        = 1'b0;
    alu_src_a   = 1'b0;
    pc_src      = 2'b00;
    alu_src_b   = 2'b00;
    mult_start  = 1'b0;
    uart_rx_ack = 1'b0;
    if (reset) begin
      unique case (state_q)
        S_FETCH: begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
        end
        S_DECODE: begin
          alu_src_b  = 2'b11;
          mult_start = (flag_J_type == 2'd0) && !is_branch && !immediate_src && mult_operation;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_src_b = flag_I_type ? 2'b10 : 2'b00;
        end
        S_MEM: begin
          iord      = 1'b1;
          mem_write = is_store;
        end
        S_WRITEBACK: reg_write = !no_wb;
        S_BRANCH: begin
          alu_src_a = 1'b1;
          pc_src    = 2'b01;
          pc_write  = br_taken;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_src    = (flag_J_type == 2'd2) ? 2'b11 : 2'b10;
          reg_write = (opcode == OP_JAL);
        end
        S_WAIT:  uart_rx_ack = wait_uart_q && uart_rx_valid;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      wait_uart_q <= 1'b0;
      retired_q   <= 32'd0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // the pre-edge values, independent of statement order.
      state_q     <= state_d;
      wait_uart_q <= wait_uart_d;
      retired_q   <= retired_d;
    end
  end

  assign state         = state_q;
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mips_control_fsm
//   Self-checking bench. Each instruction is described by the list of cycles it
//   should take and by what each of those cycles must drive. That list becomes
//   the expected trace. One negedge process compares the DUT against it. A few
//   directed sequences also pin the state path and the counter with literals.
// -----------------------------------------------------------------------------
module tb_mips_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        flag_R_type, flag_I_type, flag_lw, flag_sw;
  logic        mult_operation, mflo_flag, immediate_src;
  logic [1:0]  flag_J_type;
  logic        zero, mult_done, uart_rx_valid;
  logic        pc_write, ir_write, mem_write, reg_write, iord, alu_src_a;
  logic [1:0]  pc_src, alu_src_b;
  logic        mult_start, uart_rx_ack;
  logic [2:0]  state;
  logic [31:0] instr_retired;

  mips_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .flag_R_type(flag_R_type), .flag_I_type(flag_I_type),
    .flag_lw(flag_lw), .flag_sw(flag_sw),
    .mult_operation(mult_operation), .mflo_flag(mflo_flag),
    .immediate_src(immediate_src), .flag_J_type(flag_J_type),
    .zero(zero), .mult_done(mult_done), .uart_rx_valid(uart_rx_valid),
    .pc_write(pc_write), .ir_write(ir_write), .mem_write(mem_write),
    .reg_write(reg_write), .iord(iord), .alu_src_a(alu_src_a),
    .pc_src(pc_src), .alu_src_b(alu_src_b),
    .mult_start(mult_start), .uart_rx_ack(uart_rx_ack),
    .state(state), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  typedef enum int {
    K_RTYPE, K_ITYPE, K_LW, K_SW, K_LUI, K_BEQ, K_BNE,
    K_J, K_JAL, K_JR, K_MULT, K_UART, K_UNK
  } kind_e;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_write, ir_write, mem_write, reg_write, iord, alu_src_a;
    logic [1:0] pc_src, alu_src_b;
    logic       mult_start, uart_rx_ack;
  } obs_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  obs_t        exp_o;
  logic [31:0] exp_ret;
  bit          exp_valid = 1'b0;
  int          model_ret = 0;
  logic [2:0]  seen[$];
  obs_t        act;

  task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, a, e);
    end
  endtask

  // Single compare process, sampling away from the active edge.
  always @(negedge clk) begin
    if (exp_valid) begin
      act = '{st: state, pc_write: pc_write, ir_write: ir_write, mem_write: mem_write,
              reg_write: reg_write, iord: iord, alu_src_a: alu_src_a, pc_src: pc_src,
              alu_src_b: alu_src_b, mult_start: mult_start, uart_rx_ack: uart_rx_ack};
      check("outputs", 64'(act), 64'(exp_o));
      check("instr_retired", 64'(instr_retired), 64'(exp_ret));
      seen.push_back(state);
    end
  end

  function automatic obs_t mk(input logic [2:0] s);
    obs_t o;
    o = '0;
    o.st = s;
    return o;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: apply the per-cycle inputs, publish the expectation,
  // advance to 1 ns past the next rising edge.
  task automatic step(input obs_t e, input logic z, input logic md, input logic uv);
    zero          = z;
    mult_done     = md;
    uart_rx_valid = uv;
    exp_o         = e;
    exp_ret       = 32'(model_ret);
    exp_valid     = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] path_since(input int start);
    logic [31:0] p;
    p = 32'd1;  // sentinel so a leading FETCH (0) still shows up
    for (int i = start; i < seen.size(); i++) p = {p[28:0], seen[i]};
    return p;
  endfunction

  task automatic set_instr(input kind_e k);
    opcode = 6'h00; flag_R_type = 0; flag_I_type = 0; flag_lw = 0; flag_sw = 0;
    mult_operation = 0; mflo_flag = 0; immediate_src = 0; flag_J_type = 2'd0;
    case (k)
      K_RTYPE: begin flag_R_type = 1; mflo_flag = rnd(); end
      K_ITYPE: begin opcode = 6'h08; flag_I_type = 1; end
      K_LW:    begin opcode = 6'h23; flag_I_type = 1; flag_lw = 1; end
      K_SW:    begin opcode = 6'h2B; flag_I_type = 1; flag_sw = 1; end
      K_LUI:   begin opcode = 6'h0F; flag_I_type = 1; flag_sw = 1; end
      K_BEQ:   begin opcode = 6'h04; flag_I_type = 1; end
      K_BNE:   begin opcode = 6'h05; flag_I_type = 1; end
      K_J:     begin opcode = 6'h02; flag_J_type = 2'd1; end
      K_JAL:   begin opcode = 6'h03; flag_J_type = 2'd1; end
      K_JR:    begin flag_R_type = 1; flag_J_type = 2'd2; end
      K_MULT:  begin flag_R_type = 1; mult_operation = 1; end
      // immediate_src wins over mult_operation, so randomising it is harmless.
      K_UART:  begin opcode = 6'h1C; immediate_src = 1; mult_operation = rnd(); end
      default: opcode = 6'h3E;  // unknown opcode, no flags
    endcase
  endtask

  // Expected behaviour of one instruction. n = WAIT cycles before the
  // multiplier/UART is ready; z < 0 means a random zero flag in BRANCH.
  task automatic run_instr(input kind_e k, input int n, input int z);
    obs_t e;
    logic zb;
    set_instr(k);
    e = mk(3'd0); e.ir_write = 1; e.pc_write = 1; e.alu_src_b = 2'b01;
    step(e, rnd(), rnd(), rnd());
    e = mk(3'd1); e.alu_src_b = 2'b11; e.mult_start = (k == K_MULT);
    step(e, rnd(), rnd(), rnd());
    case (k)
      K_BEQ, K_BNE: begin
        zb = (z < 0) ? rnd() : z[0];
        e = mk(3'd5); e.alu_src_a = 1; e.pc_src = 2'b01;
        e.pc_write = (k == K_BEQ) ? zb : !zb;
        step(e, zb, rnd(), rnd());
      end
      K_J, K_JAL, K_JR: begin
        e = mk(3'd6); e.pc_write = 1;
        e.pc_src = (k == K_JR) ? 2'b11 : 2'b10;
        e.reg_write = (k == K_JAL);
        step(e, rnd(), rnd(), rnd());
      end
      K_MULT: begin
        for (int i = 0; i < n; i++) step(mk(3'd7), rnd(), 1'b0, rnd());
        step(mk(3'd7), rnd(), 1'b1, rnd());
      end
      K_UART: begin
        for (int i = 0; i < n; i++) step(mk(3'd7), rnd(), rnd(), 1'b0);
        e = mk(3'd7); e.uart_rx_ack = 1;
        step(e, rnd(), rnd(), 1'b1);
        e = mk(3'd4); e.reg_write = 1;
        step(e, rnd(), rnd(), rnd());
      end
      default: begin
        e = mk(3'd2); e.alu_src_a = 1;
        e.alu_src_b = (k inside {K_ITYPE, K_LW, K_SW, K_LUI}) ? 2'b10 : 2'b00;
        step(e, rnd(), rnd(), rnd());
        if (k == K_LW || k == K_SW) begin
          e = mk(3'd3); e.iord = 1; e.mem_write = (k == K_SW);
          step(e, rnd(), rnd(), rnd());
        end
        if (k != K_SW) begin
          e = mk(3'd4); e.reg_write = 1;
          step(e, rnd(), rnd(), rnd());
        end
      end
    endcase
    model_ret++;
  endtask

  initial begin
    int start;
    reset = 1'b0;
    set_instr(K_RTYPE);
    zero = 0; mult_done = 0; uart_rx_valid = 0;
    // Held in reset across several edges: every output 0, counter 0.
    repeat (3) step(mk(3'd0), rnd(), rnd(), rnd());
    reset = 1'b1;

    start = seen.size();
    run_instr(K_LW, 0, -1);
    check("lw_path", 64'(path_since(start)), 64'('o101234));
    check("lw_retired", 64'(instr_retired), 64'd1);

    start = seen.size();
    run_instr(K_BEQ, 0, 1);
    check("beq_taken_path", 64'(path_since(start)), 64'('o1015));
    start = seen.size();
    run_instr(K_BEQ, 0, 0);
    check("beq_not_taken_path", 64'(path_since(start)), 64'('o1015));

    start = seen.size();
    run_instr(K_LUI, 0, -1);
    check("lui_path", 64'(path_since(start)), 64'('o10124));

    // mult_done rises 5 cycles after DECODE: 4 idle WAIT cycles + the done cycle.
    start = seen.size();
    run_instr(K_MULT, 4, -1);
    check("mult_path", 64'(path_since(start)), 64'('o10177777));

    start = seen.size();
    run_instr(K_UART, 3, -1);
    check("uart_path", 64'(path_since(start)), 64'('o10177774));
    check("retired_after_directed", 64'(instr_retired), 64'd6);

    // jal aborted by reset in its JUMP cycle.
    set_instr(K_JAL);
    begin
      obs_t e;
      e = mk(3'd0); e.ir_write = 1; e.pc_write = 1; e.alu_src_b = 2'b01;
      step(e, rnd(), rnd(), rnd());
      e = mk(3'd1); e.alu_src_b = 2'b11;
      step(e, rnd(), rnd(), rnd());
      #2;
      reset     = 1'b0;
      model_ret = 0;
      exp_o     = mk(3'd0);
      exp_ret   = 32'd0;
      @(posedge clk);
      #1;
      repeat (2) step(mk(3'd0), rnd(), rnd(), rnd());
      reset = 1'b1;
    end
    check("post_reset_state", 64'(state), 64'd0);
    check("post_reset_retired", 64'(instr_retired), 64'd0);

    // Randomised instruction stream.
    for (int i = 0; i < 200; i++)
      run_instr(kind_e'($urandom_range(0, 12)), int'($urandom_range(0, 6)), -1);

    exp_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
